// File: rtl/led_step_counter.sv
// Debounced up/down stepper feeding the 12-LED one-hot decoder (cnt_n = ~pos).
// Optional auto-repeat while a button is held: define LED_STEP_REPEAT_EN.
module led_step_counter #(
  parameter int DEB_CNT = 500000,
  parameter int MAX_POS = 11
`ifdef LED_STEP_REPEAT_EN
  ,
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_n,
  input  logic       btn_dn_n,
  output logic [3:0] pos,
  output logic [3:0] cnt_n,
  output logic       step
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } deb_state_e;

  localparam logic [19:0] DEB_LAST = 20'(DEB_CNT - 1);
  localparam logic [3:0]  POS_MAX  = 4'(MAX_POS);

  // Index 0 is the up button, index 1 the down button throughout.
  logic [1:0]  meta_q, meta_d;
  logic [1:0]  sync_q, sync_d;

  deb_state_e  state_q   [2];
  deb_state_e  state_d   [2];
  logic [19:0] deb_cnt_q [2];
  logic [19:0] deb_cnt_d [2];
  logic [1:0]  press_evt;
  logic [1:0]  rep_evt;

  logic [3:0]  pos_q, pos_d;
  logic [3:0]  cnt_n_q, cnt_n_d;
  logic        step_q, step_d;
  logic        up_evt, dn_evt;

  // Two-flop synchronisers; everything downstream looks only at sync_q.
  always_comb begin
    meta_d = {btn_dn_n, btn_up_n};
    sync_d = meta_q;
  end

  // Debounce FSMs. The press event is decoded from the current state so the
  // position register can take it on the very edge the FSM enters PRESSED.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]   = state_q[i];
      deb_cnt_d[i] = deb_cnt_q[i];
      press_evt[i] = 1'b0;
      case (state_q[i])
        RELEASED: begin
          if (!sync_q[i]) begin
            state_d[i]   = PRESS_CHK;
            deb_cnt_d[i] = '0;
          end
        end
        PRESS_CHK: begin
          if (sync_q[i]) begin
            state_d[i] = RELEASED;
          end else if (deb_cnt_q[i] == DEB_LAST) begin
            state_d[i]   = PRESSED;
            press_evt[i] = 1'b1;
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + 20'd1;
          end
        end
        PRESSED: begin
          if (sync_q[i]) begin
            state_d[i]   = RELEASE_CHK;
            deb_cnt_d[i] = '0;
          end
        end
        RELEASE_CHK: begin
          if (!sync_q[i]) begin
            state_d[i] = PRESSED;
          end else if (deb_cnt_q[i] == DEB_LAST) begin
            state_d[i] = RELEASED;
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + 20'd1;
          end
        end
        default: begin
          state_d[i]   = RELEASED;
          deb_cnt_d[i] = '0;
        end
      endcase
    end
  end

`ifdef LED_STEP_REPEAT_EN
  localparam int              REP_W      = $clog2(REPEAT_DLY + 1);
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DLY - 1);
  // Reloading to DLY-PER makes every later repeat land REPEAT_PER cycles apart.
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DLY - REPEAT_PER);

  logic [REP_W-1:0] rep_cnt_q [2];
  logic [REP_W-1:0] rep_cnt_d [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rep_evt[i]   = 1'b0;
      rep_cnt_d[i] = '0;
      if (state_q[i] == PRESSED && state_d[i] == PRESSED) begin
        if (rep_cnt_q[i] == REP_LAST) begin
          rep_evt[i]   = 1'b1;
          rep_cnt_d[i] = REP_RELOAD;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rep_cnt_q[i] <= '0;
      end else begin
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end
`else
  always_comb begin
    rep_evt = 2'b00;
  end
`endif

  // Step logic: simultaneous up and down cancel out.
  always_comb begin
    up_evt  = press_evt[0] | rep_evt[0];
    dn_evt  = press_evt[1] | rep_evt[1];
    pos_d   = pos_q;
    step_d  = 1'b0;
    if (up_evt && !dn_evt) begin
      pos_d  = (pos_q == POS_MAX) ? 4'd0 : pos_q + 4'd1;
      step_d = 1'b1;
    end else if (dn_evt && !up_evt) begin
      pos_d  = (pos_q == 4'd0) ? POS_MAX : pos_q - 4'd1;
      step_d = 1'b1;
    end
    cnt_n_d = ~pos_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q  <= 2'b11;
      sync_q  <= 2'b11;
      pos_q   <= 4'd0;
      cnt_n_q <= 4'b1111;
      step_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      pos_q   <= pos_d;
      cnt_n_q <= cnt_n_d;
      step_q  <= step_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        state_q[i]   <= RELEASED;
        deb_cnt_q[i] <= '0;
      end else begin
        state_q[i]   <= state_d[i];
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  assign pos   = pos_q;
  assign cnt_n = cnt_n_q;
  assign step  = step_q;

endmodule

// File: tb/tb_led_step_counter.sv
// Directed bench for led_step_counter (DEB_CNT=4, MAX_POS=11, repeat 20/8).
// Every step pulse is matched against a queue of expected positions.
module tb_led_step_counter;

  logic       clk;
  logic       rst_n;
  logic       btn_up_n;
  logic       btn_dn_n;
  logic [3:0] pos;
  logic [3:0] cnt_n;
  logic       step;

  int n_vec;
  int n_err;
  int step_cnt;
  int base;
  logic [31:0] exp_q[$];

  led_step_counter #(
    .DEB_CNT(4),
    .MAX_POS(11)
`ifdef LED_STEP_REPEAT_EN
    ,
    .REPEAT_DLY(20),
    .REPEAT_PER(8)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up_n (btn_up_n),
    .btn_dn_n (btn_dn_n),
    .pos      (pos),
    .cnt_n    (cnt_n),
    .step     (step)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drivers: inputs change on the falling edge, outputs are read there too.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic press(input bit is_up, input int hold);
    if (is_up) btn_up_n = 1'b0;
    else       btn_dn_n = 1'b0;
    tick(hold);
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    tick(12);
  endtask

  // Scoreboard: each step pulse must match the next expected position.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && step === 1'b1) begin
      step_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_step", {28'd0, pos}, 32'hff);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check_val("step_pos", {28'd0, pos}, e);
        check_val("step_cnt_n", {28'd0, cnt_n}, {28'd0, ~e[3:0]});
      end
    end
  end

  int bnc_lvl[7] = '{0, 1, 0, 1, 0, 1, 0};
  int bnc_len[7] = '{2, 1, 3, 2, 1, 1, 12};

  initial begin
    n_vec = 0;
    n_err = 0;
    step_cnt = 0;
    rst_n = 1'b0;
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;

    // 1. reset values
    tick(2);
    check_val("rst_pos", {28'd0, pos}, 32'd0);
    check_val("rst_cnt_n", {28'd0, cnt_n}, 32'hf);
    check_val("rst_step", {31'd0, step}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 2. clean press: new pos 7 edges after the raw edge
    base = step_cnt;
    exp_q.push_back(32'd1);
    btn_up_n = 1'b0;
    tick(6);
    check_val("clean_pos_before", {28'd0, pos}, 32'd0);
    tick(1);
    check_val("clean_pos", {28'd0, pos}, 32'd1);
    check_val("clean_cnt_n", {28'd0, cnt_n}, 32'he);
    check_val("clean_step_hi", {31'd0, step}, 32'd1);
    tick(1);
    check_val("clean_step_lo", {31'd0, step}, 32'd0);
    tick(2);
    btn_up_n = 1'b1;
    tick(12);
    check_val("clean_steps", step_cnt - base, 32'd1);

    // 3. bouncy press gives one step
    do_reset();
    base = step_cnt;
    exp_q.push_back(32'd1);
    for (int i = 0; i < 7; i++) begin
      btn_up_n = bnc_lvl[i][0];
      tick(bnc_len[i]);
    end
    btn_up_n = 1'b1;
    tick(12);
    check_val("bounce_pos", {28'd0, pos}, 32'd1);
    check_val("bounce_steps", step_cnt - base, 32'd1);

    // 4. wrap in both directions
    do_reset();
    exp_q.push_back(32'd11);
    press(1'b0, 10);
    check_val("wrap_dn_pos", {28'd0, pos}, 32'd11);
    check_val("wrap_dn_cnt_n", {28'd0, cnt_n}, 32'h4);
    exp_q.push_back(32'd0);
    press(1'b1, 10);
    check_val("wrap_up_pos", {28'd0, pos}, 32'd0);
    check_val("wrap_up_cnt_n", {28'd0, cnt_n}, 32'hf);
    exp_q.push_back(32'd1);
    press(1'b1, 10);
    exp_q.push_back(32'd2);
    press(1'b1, 10);
    exp_q.push_back(32'd1);
    press(1'b0, 10);
    check_val("up_dn_pos", {28'd0, pos}, 32'd1);

    // 5. simultaneous presses cancel
    base = step_cnt;
    btn_up_n = 1'b0;
    btn_dn_n = 1'b0;
    tick(10);
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    tick(12);
    check_val("both_pos", {28'd0, pos}, 32'd1);
    check_val("both_steps", step_cnt - base, 32'd0);

    // 5b. reset in the middle of PRESS_CHK
    btn_up_n = 1'b0;
    tick(4);
    rst_n = 1'b0;
    btn_up_n = 1'b1;
    tick(1);
    check_val("midrst_pos", {28'd0, pos}, 32'd0);
    rst_n = 1'b1;
    tick(12);
    check_val("midrst_pos_after", {28'd0, pos}, 32'd0);
    check_val("midrst_steps", step_cnt - base, 32'd0);

    // 5c. button held through reset issues exactly one press
    base = step_cnt;
    exp_q.push_back(32'd1);
    btn_up_n = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check_val("hold_rst_before", {28'd0, pos}, 32'd0);
    tick(1);
    check_val("hold_rst_pos", {28'd0, pos}, 32'd1);
    btn_up_n = 1'b1;
    tick(12);
    check_val("hold_rst_steps", step_cnt - base, 32'd1);

    // 6. long hold: auto-repeat only when enabled
    do_reset();
    base = step_cnt;
`ifdef LED_STEP_REPEAT_EN
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd4);
`else
    exp_q.push_back(32'd1);
`endif
    btn_up_n = 1'b0;
    tick(7);
    check_val("hold_qual_pos", {28'd0, pos}, 32'd1);
    tick(20);
`ifdef LED_STEP_REPEAT_EN
    check_val("hold_rep1_pos", {28'd0, pos}, 32'd2);
`else
    check_val("hold_rep1_pos", {28'd0, pos}, 32'd1);
`endif
    tick(8);
`ifdef LED_STEP_REPEAT_EN
    check_val("hold_rep2_pos", {28'd0, pos}, 32'd3);
`else
    check_val("hold_rep2_pos", {28'd0, pos}, 32'd1);
`endif
    tick(12);
    btn_up_n = 1'b1;
    tick(12);
`ifdef LED_STEP_REPEAT_EN
    check_val("hold_end_pos", {28'd0, pos}, 32'd4);
    check_val("hold_steps", step_cnt - base, 32'd4);
`else
    check_val("hold_end_pos", {28'd0, pos}, 32'd1);
    check_val("hold_steps", step_cnt - base, 32'd1);
`endif

    check_val("steps_missing", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_step_counter.md
Name: led_step_counter

Overview:
Upstream stage for the 12-LED one-hot decoder. Takes two raw active-low pushbuttons (up/down), synchronises and debounces them, and steps a position 0..MAX_POS with wrap-around. Drives the decoder's 4-bit active-low code input (cnt_n = ~pos), so released buttons and reset both light LED 0.

Parameters:
DEB_CNT, 500000, cycles a synchronised input must hold its new level before it is accepted (10 ms at 50 MHz); legal range 2..2^20-1
MAX_POS, 11, highest position; wrap point; legal range 1..15
REPEAT_DLY, 25000000, hold time before the first auto-repeat step (optional feature only)
REPEAT_PER, 5000000, period between later auto-repeat steps (optional feature only)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
btn_up_n  input  1  raw up button, active-low, asynchronous, bouncing
btn_dn_n  input  1  raw down button, active-low, asynchronous, bouncing
pos  output  4  current position, registered, true polarity
cnt_n  output  4  ~pos, registered; feeds the decoder's inpulse input
step  output  1  one-cycle pulse in the cycle pos/cnt_n first show a new value

Behaviour:
- One clock domain. Reset is synchronous and active-low: sampled only on the rising edge of clk.
- Reset values: pos=0, cnt_n=4'b1111, step=0, synchroniser flops=1, debounce FSMs=RELEASED, all counters=0.
- Synchroniser: 2 flops per button. All later logic uses only the synchronised level s (0 = pressed).
- Debounce FSM, one per button. States: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. Each FSM has a 20-bit counter.
  - RELEASED: s=0 -> PRESS_CHK, counter cleared.
  - PRESS_CHK: s=1 -> RELEASED (bounce). Counter reaches DEB_CNT-1 with s=0 -> PRESSED, and a press event is asserted for 1 cycle. Otherwise the counter increments.
  - PRESSED: s=1 -> RELEASE_CHK, counter cleared.
  - RELEASE_CHK: s=0 -> PRESSED (bounce, no event). Counter reaches DEB_CNT-1 with s=1 -> RELEASED. Release produces no event.
- Step logic is registered, 1 cycle after the event.
  - Up event only: pos <= (pos==MAX_POS) ? 0 : pos+1.
  - Down event only: pos <= (pos==0) ? MAX_POS : pos-1.
  - Both events in the same cycle: no change, step=0.
  - step=1 in the same cycle the new pos appears.
  - Latency from a clean raw edge to the new pos: 2 (sync) + DEB_CNT + 1 cycles.
- pos never exceeds MAX_POS. The 4-bit arithmetic is explicit, so there is no implicit overflow.
- A button held through reset: after reset deasserts, the FSM passes through PRESS_CHK and issues exactly one press after DEB_CNT cycles.
- Reset mid-debounce or mid-hold: immediate return to reset values. No event is emitted in the reset cycle.
- One button held while the other is pressed: each FSM is independent, and the second press steps normally.

Optional Feature:
Macro LED_STEP_REPEAT_EN.
- Defined: a per-button repeat counter runs while the FSM is in PRESSED (cleared on entry and in every other state).
  - When it reaches REPEAT_DLY-1, a repeat event is emitted and the counter reloads.
  - Each subsequent event is emitted after REPEAT_PER cycles.
  - Repeat events use the same step and simultaneity rules as press events.
- Undefined: no repeat counters or parameters are used. Exactly one step per qualified press regardless of hold time.

Test Plan:
(Sim uses DEB_CNT=4, REPEAT_DLY=20, REPEAT_PER=8.)
1. Reset, then hold rst_n=0 for 2 cycles -> pos=0, cnt_n=4'b1111, step=0.
2. Clean up press held 10 cycles, then released -> pos 0->1 at cycle 2+4+1 after the falling edge, cnt_n=4'b1110, exactly one step pulse.
3. Up press with 3 bounces shorter than 4 cycles before settling -> exactly one step, pos=1.
4. From pos=11, one up press gives pos=0 (cnt_n=4'b1111). From pos=0, one down press gives pos=11 (cnt_n=4'b0100).
5. Up and down asserted on the same cycle with identical clean edges -> no step, pos unchanged. rst_n pulsed low mid-PRESS_CHK -> no step, pos=0.
6. With LED_STEP_REPEAT_EN, up held for 40 cycles after qualification -> steps at qualification, +20, +28 and +36 cycles, ending at pos=4. Without the macro -> pos=1.
